tm_mul_arbiter: RTL and testbench
=================================

# tm_mul_arbiter

Round-robin arbiter and scheduler that shares one pipelined signed tree multiplier (TMSeq-style: operands in, `2*WIDTH` product out after a fixed latency) among `NREQ` requesters. It accepts at most one operand pair per cycle through valid/ready handshakes and drives the multiplier's operand inputs. It tracks each in-flight operation's requester tag and returns the product to the originating requester. It sits between the multiplier and the client blocks, with the multiplier instantiated beside it.

## Interface
- `NREQ`, default 4: number of requesters, minimum 2.
- `WIDTH`, default 32: operand width, signed two's complement.
- `MUL_LAT`, default 1: cycles from `mul_a`/`mul_b` change to a valid `mul_result`, minimum 1.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NREQ: per-requester operand valid.
- `req_a` in NREQ*WIDTH: packed operands A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b` in NREQ*WIDTH: packed operands B, same packing.
- `req_ready` out NREQ: one-hot grant; combinational.
- `mul_a` out WIDTH: registered operand to the multiplier.
- `mul_b` out WIDTH: registered operand to the multiplier.
- `mul_result` in 2*WIDTH: multiplier product.
- `rsp_valid` out NREQ: one-hot, registered, one-cycle result strobe.
- `rsp_data` out 2*WIDTH: registered product, shared by all requesters.
- `grant_cnt` out NREQ*16: per-requester grant counters; present only with `TM_ARB_STATS_EN`.

## Operation
- Arbitration
  - Round-robin pointer `last` holds the most recent grant. The search starts at `last+1` and wraps modulo NREQ.
  - `req_ready[i]` is high only for the first requester found with `req_valid` set.
  - `req_ready` is all zero while `reset` is high.
  - A handshake is `req_valid[i] && req_ready[i]`. On a handshake, `last` updates to i; otherwise `last` holds.
- Issue
  - On a handshake, the selected operands register into `mul_a`/`mul_b`.
  - A tag `{valid, index}` enters stage 0 of a tag shift pipe.
  - With no handshake, `mul_a`/`mul_b` hold their values and a bubble tag (valid=0) enters the pipe.
- Tag pipe
  - Depth `MUL_LAT+1`. It advances every cycle and has no stall or backpressure.
- Return
  - When the last tag stage is valid, `rsp_data` captures `mul_result` and `rsp_valid[index]` pulses high for one cycle.
  - Otherwise `rsp_valid` is 0 and `rsp_data` holds its value.
- Arithmetic
  - The arbiter never alters operands or product; the product is the full signed `2*WIDTH` result.
- Ordering
  - Results return in issue order.
  - Requesters must accept `rsp_valid` unconditionally; there is no response backpressure.
- Throughput
  - One issue per cycle. Any single requester may issue back-to-back when it is the only one requesting.

## Timing
- Reset values: `last=NREQ-1` (so requester 0 wins first), `mul_a=0`, `mul_b=0`, all tags invalid, `rsp_valid=0`, `rsp_data=0`, `grant_cnt=0`.
- Latency: handshake at cycle t; `mul_a`/`mul_b` valid at t+1; product sampled at t+1+MUL_LAT; `rsp_valid` high at t+2+MUL_LAT. This is 3 cycles for MUL_LAT=1.
- Reset mid-operation: all in-flight tags are discarded and no `rsp_valid` is emitted for them, including in the cycle after reset deasserts.
- Simultaneous events: an issue and a return in the same cycle are independent, and both occur.
- No requests: pipe fills with bubbles and outputs hold.
- Single requester valid: granted every cycle regardless of `last`.

## Configuration
- Macro: `TM_ARB_STATS_EN`.
- Defined:
  - `grant_cnt` port exists.
  - Requester i's 16-bit counter increments on each of its handshakes.
  - Counters saturate at 0xFFFF.
  - Counters clear on `reset`.
- Undefined:
  - Port and counters are absent; remaining behaviour is identical.

## Structure
- Package `tm_arb_pkg`:
  - `TM_ARB_CNT_W = 16`.
  - Packed tag typedef `{logic valid; logic [$clog2(NREQ)-1:0] idx}`, parameterised via a localparam in the module.
  - Helper function for round-robin rotation.
- Sub-module `tm_rr_picker`: purely combinational. Takes `req_valid` and `last` and produces the one-hot grant and the granted index.
- The multiplier is not instantiated inside `tm_mul_arbiter`; the bench and top level wire TMSeq to the `mul_*` ports.

## Test plan
- Single request: requester 0, a=50, b=-40, one cycle.
  - `req_ready[0]=1` that cycle.
  - 3 cycles later, `rsp_valid=4'b0001` and `rsp_data=64'hFFFF_FFFF_FFFF_F830` (-2000).
- Full contention: all four requesters hold valid with a=i+1, b=10.
  - Grants rotate 0,1,2,3,0,1.
  - Responses arrive 10,20,30,40,10,20 with matching one-hot `rsp_valid`.
- Back-to-back single requester: requester 2 issues (-80,-65), (-10,325), (-999,999) on consecutive cycles.
  - Responses 5200, -3250, -998001 on consecutive cycles, all to `rsp_valid[2]`.
- Pointer fairness: requester 3 granted, then requesters 0 and 3 both valid.
  - Requester 0 is granted next, then requester 3.
- Reset mid-flight: issue two operations, assert `reset` the cycle after the second issue.
  - No `rsp_valid` pulses afterwards.
  - `mul_a=0`, `rsp_data=0`.
  - The next single request from requester 1 is granted immediately.
- Stats (`TM_ARB_STATS_EN`): 70000 grants to requester 1.
  - `grant_cnt[1]=0xFFFF`, others 0.
  - Counters return to 0 after `reset`.

Source files
------------

// File: rtl/tm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tm_arb_pkg
// Description : Shared constants and round-robin helper for tm_mul_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package tm_arb_pkg;

  localparam int TM_ARB_CNT_W = 16;

  // Wraps a search position that has run at most one lap past n back into range.
  function automatic int rr_wrap(input int pos, input int n);
    return (pos >= n) ? pos - n : pos;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tm_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : tm_rr_picker
// Description : Combinational round-robin picker; searches from last+1 and wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module tm_rr_picker
  import tm_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_valid_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_any_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    cand        = '0;
    found       = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'(rr_wrap(int'(last_i) + k, NREQ));
      if (!found && req_valid_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
      end
    end
    grant_any_o = found;
  end

endmodule
`default_nettype wire

// File: rtl/tm_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tm_mul_arbiter
// Description : Round-robin scheduler sharing one pipelined multiplier among
//               NREQ requesters; tags route each product back to its issuer.
//               Optional per-requester grant counters under TM_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tm_mul_arbiter
  import tm_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*WIDTH-1:0]        req_a,
  input  logic [NREQ*WIDTH-1:0]        req_b,
  output logic [NREQ-1:0]              req_ready,
  output logic [WIDTH-1:0]             mul_a,
  output logic [WIDTH-1:0]             mul_b,
  input  logic [2*WIDTH-1:0]           mul_result,
  output logic [NREQ-1:0]              rsp_valid,
`ifdef TM_ARB_STATS_EN
  output logic [NREQ*TM_ARB_CNT_W-1:0] grant_cnt,
`endif
  output logic [2*WIDTH-1:0]           rsp_data
);

  localparam int IDX_W = $clog2(NREQ);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  logic [NREQ-1:0]    grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic               hs;
  logic [NREQ-1:0]    hs_vec;

  logic [IDX_W-1:0]   last_q, last_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  tag_t               tag_d;
  tag_t               tag_q [0:MUL_LAT];
  logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [2*WIDTH-1:0] rsp_data_q, rsp_data_d;

  tm_rr_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_valid_i (req_valid),
    .last_i      (last_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

  assign req_ready = reset ? '0 : grant;
  assign hs        = grant_any & ~reset;
  assign hs_vec    = req_valid & req_ready;

  always_comb begin
    last_d      = last_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    tag_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (hs) begin
      last_d    = grant_idx;
      mul_a_d   = req_a[grant_idx*WIDTH +: WIDTH];
      mul_b_d   = req_b[grant_idx*WIDTH +: WIDTH];
      tag_d     = '{valid: 1'b1, idx: grant_idx};
    end
    // The oldest tag lines up with the product of the operands it was issued with.
    if (tag_q[MUL_LAT].valid) begin
      rsp_valid_d = NREQ'(1) << tag_q[MUL_LAT].idx;
      rsp_data_d  = mul_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q      <= IDX_W'(NREQ - 1);
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int i = 0; i <= MUL_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      last_q      <= last_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      tag_q[0]    <= tag_d;
      for (int i = 1; i <= MUL_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

`ifdef TM_ARB_STATS_EN
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
    logic [TM_ARB_CNT_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
      end else if (hs_vec[gi] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + TM_ARB_CNT_W'(1);
      end
    end
    assign grant_cnt[gi*TM_ARB_CNT_W +: TM_ARB_CNT_W] = cnt_q;
  end
`else
  logic unused_hs_vec;
  assign unused_hs_vec = ^hs_vec;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tm_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tm_mul_arbiter
// Description : Scoreboard bench for tm_mul_arbiter with a behavioural
//               pipelined multiplier; grant counters checked under TM_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tm_mul_arbiter;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 1;

  logic                      clk;
  logic                      reset;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ*WIDTH-1:0]     req_a;
  logic [NREQ*WIDTH-1:0]     req_b;
  logic [NREQ-1:0]           req_ready;
  logic [WIDTH-1:0]          mul_a;
  logic [WIDTH-1:0]          mul_b;
  logic [2*WIDTH-1:0]        mul_result;
  logic [NREQ-1:0]           rsp_valid;
  logic [2*WIDTH-1:0]        rsp_data;
`ifdef TM_ARB_STATS_EN
  logic [NREQ*16-1:0]        grant_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [NREQ+2*WIDTH-1:0] exp_q [$];

  tm_mul_arbiter #(
    .NREQ    (NREQ),
    .WIDTH   (WIDTH),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .rsp_valid  (rsp_valid),
`ifdef TM_ARB_STATS_EN
    .grant_cnt  (grant_cnt),
`endif
    .rsp_data   (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural pipelined signed multiplier standing in for TMSeq.
  logic signed [2*WIDTH-1:0] mpipe [MUL_LAT];
  always_ff @(posedge clk) begin
    mpipe[0] <= $signed(mul_a) * $signed(mul_b);
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_result = mpipe[MUL_LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid %b data %h expected no response", rsp_valid, rsp_data);
      end else begin
        logic [NREQ+2*WIDTH-1:0] e;
        e = exp_q.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(e[NREQ+2*WIDTH-1:2*WIDTH]));
        chk("rsp_data", rsp_data, e[2*WIDTH-1:0]);
      end
    end
  end

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  // Called at posedge+1 after inputs are set; checks the grant and queues the product.
  task automatic step(input logic [NREQ-1:0] exp_grant, input logic [63:0] exp_data, input bit push);
    #1;
    chk("req_ready", 64'(req_ready), 64'(exp_grant));
    if (push && exp_grant != '0) exp_q.push_back({exp_grant, exp_data});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("drain_outstanding", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    @(posedge clk); #1;
    req_valid = '1;
    #1;
    chk("ready_in_reset", 64'(req_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mul_a", 64'(mul_a), 64'd0);
    chk("reset_mul_b", 64'(mul_b), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_data", rsp_data, 64'd0);

    // Full contention: pointer starts at NREQ-1 so requester 0 wins first.
    for (int i = 0; i < NREQ; i++) set_req(i, i + 1, 10);
    reset = 1'b0;
    step(4'b0001, 64'd10, 1);
    step(4'b0010, 64'd20, 1);
    step(4'b0100, 64'd30, 1);
    step(4'b1000, 64'd40, 1);
    step(4'b0001, 64'd10, 1);
    step(4'b0010, 64'd20, 1);
    req_valid = '0;
    drain();

    // Single request with exact latency check.
    set_req(0, 50, -40);
    req_valid = 4'b0001;
    step(4'b0001, 64'hFFFF_FFFF_FFFF_F830, 1);
    req_valid = '0;
    @(negedge clk); chk("lat_t1", 64'(rsp_valid), 64'd0);
    @(negedge clk); chk("lat_t2", 64'(rsp_valid), 64'd0);
    @(negedge clk); chk("lat_t3", 64'(rsp_valid), 64'b0001);
    @(posedge clk); #1;
    drain();

    // Back-to-back single requester.
    req_valid = 4'b0100;
    set_req(2, -80, -65);  step(4'b0100, 64'd5200, 1);
    set_req(2, -10, 325);  step(4'b0100, -64'sd3250, 1);
    set_req(2, -999, 999); step(4'b0100, -64'sd998001, 1);
    req_valid = '0;
    drain();

    // Pointer fairness after requester 3 is granted.
    set_req(3, -6, 9);
    req_valid = 4'b1000;
    step(4'b1000, -64'sd54, 1);
    set_req(0, 7, 3);
    req_valid = 4'b1001;
    step(4'b0001, 64'd21, 1);
    step(4'b1000, -64'sd54, 1);
    req_valid = '0;
    drain();

    // Reset mid-flight: both in-flight results must be dropped.
    set_req(0, 5, 5);
    req_valid = 4'b0001;
    step(4'b0001, 64'd25, 0);
    set_req(1, 6, 6);
    req_valid = 4'b0010;
    step(4'b0010, 64'd36, 0);
    req_valid = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_mul_a", 64'(mul_a), 64'd0);
    chk("midrst_rsp_data", rsp_data, 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    set_req(1, 12, -12);
    req_valid = 4'b0010;
    step(4'b0010, -64'sd144, 1);
    req_valid = '0;
    drain();

`ifdef TM_ARB_STATS_EN
    set_req(1, 1, 1);
    req_valid = 4'b0010;
    for (int n = 0; n < 70000; n++) step(4'b0010, 64'd1, 1);
    req_valid = '0;
    drain();
    chk("cnt0_sat", 64'(grant_cnt[15:0]), 64'd0);
    chk("cnt1_sat", 64'(grant_cnt[31:16]), 64'hFFFF);
    chk("cnt2_sat", 64'(grant_cnt[47:32]), 64'd0);
    chk("cnt3_sat", 64'(grant_cnt[63:48]), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("cnt_cleared", 64'(grant_cnt), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
